// File: rtl/hilo_muldiv_if.sv
// hilo_muldiv_if: decode-side handshake and HI/LO result bundle for the mul/div sequencer.
interface hilo_muldiv_if #(parameter int WIDTH = 32);
  logic             op_valid;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             busy;
  logic             stall;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;
  modport master (output op_valid, op, src_a, src_b, flush,
                  input busy, stall, result, result_valid, hi, lo, div_by_zero);
  modport slave (input op_valid, op, src_a, src_b, flush,
                 output busy, stall, result, result_valid, hi, lo, div_by_zero);
endinterface

// File: rtl/hilo_muldiv_sequencer.sv
// hilo_muldiv_sequencer: iterative shift-add multiply / restoring divide owning HI/LO.
// Define HILO_SIGNED_EN to accept MULT/DIV, which add one sign-fix cycle.
module hilo_muldiv_sequencer #(parameter int WIDTH = 32) (
  input logic         clk,
  input logic         rst_n,
  hilo_muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, MUL, DIV `ifdef HILO_SIGNED_EN , FIX `endif} state_t;
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d, step;
  logic [WIDTH-1:0]   opb_q, opb_d, hi_q, hi_d, lo_q, lo_d, a_mag, b_mag, rn;
  logic [WIDTH:0]     msum, rs;
  logic               dbz_q, dbz_d, is_mul, is_div, is_mv, accept, ge;
`ifdef HILO_SIGNED_EN
  logic sgn_q, sgn_d, dv_q, dv_d, neg_q, neg_d, ra_q, ra_d, signed_op;
  assign signed_op = bus.op == 3'd5 || bus.op == 3'd6;
  assign is_mul    = bus.op == 3'd1 || bus.op == 3'd5;
  assign is_div    = bus.op == 3'd2 || bus.op == 3'd6;
  assign a_mag     = signed_op && bus.src_a[WIDTH-1] ? -bus.src_a : bus.src_a;
  assign b_mag     = signed_op && bus.src_b[WIDTH-1] ? -bus.src_b : bus.src_b;
`else
  assign is_mul = bus.op == 3'd1;
  assign is_div = bus.op == 3'd2;
  assign a_mag  = bus.src_a;
  assign b_mag  = bus.src_b;
`endif
  assign is_mv            = bus.op == 3'd3 || bus.op == 3'd4;
  assign bus.busy         = state_q != IDLE;
  assign bus.stall        = bus.op_valid & (is_mul | is_div | is_mv) & bus.busy;
  assign bus.result_valid = bus.op_valid & ~bus.busy & is_mv;
  assign bus.result       = !bus.result_valid ? '0 : bus.op == 3'd3 ? hi_q : lo_q;
  assign bus.hi           = hi_q;
  assign bus.lo           = lo_q;
  assign bus.div_by_zero  = dbz_q;
  assign accept = state_q == IDLE && bus.op_valid && !bus.flush && (is_mul || is_div);
  // {acc,mplr} for multiply, {rem,quo} for divide share p_q
  assign msum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, opb_q} : '0);
  assign rs   = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
  assign ge   = rs >= {1'b0, opb_q};
  assign rn   = ge ? rs[WIDTH-1:0] - opb_q : rs[WIDTH-1:0];
  assign step = state_q == DIV ? {rn, p_q[WIDTH-2:0], ge} : {msum, p_q[WIDTH-1:1]};
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    opb_d   = opb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;
`ifdef HILO_SIGNED_EN
    sgn_d   = sgn_q;
    dv_d    = dv_q;
    neg_d   = neg_q;
    ra_d    = ra_q;
`endif
    if (bus.flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == IDLE) begin
      if (accept) begin
        dbz_d = is_div && bus.src_b == '0;
        cnt_d = '0;
        if (dbz_d) begin
          hi_d = bus.src_a;
          lo_d = '1;
        end else begin
          state_d = is_div ? DIV : MUL;
          opb_d   = is_div ? b_mag : a_mag;
          p_d     = {{WIDTH{1'b0}}, is_div ? a_mag : b_mag};
`ifdef HILO_SIGNED_EN
          sgn_d = signed_op;
          dv_d  = is_div;
          neg_d = signed_op & (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
          ra_d  = signed_op & bus.src_a[WIDTH-1];
`endif
        end
      end
`ifdef HILO_SIGNED_EN
    end else if (state_q == FIX) begin
      state_d = IDLE;
      {hi_d, lo_d} = dv_q ? {ra_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH],
                             neg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0]}
                          : neg_q ? -p_q : p_q;
`endif
    end else begin
      p_d   = step;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        cnt_d   = '0;
        state_d = IDLE;
        {hi_d, lo_d} = step;
`ifdef HILO_SIGNED_EN
        if (sgn_q) begin
          state_d = FIX;
          hi_d    = hi_q;
          lo_d    = lo_q;
        end
`endif
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      opb_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
`ifdef HILO_SIGNED_EN
      sgn_q   <= 1'b0;
      dv_q    <= 1'b0;
      neg_q   <= 1'b0;
      ra_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      opb_q   <= opb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
`ifdef HILO_SIGNED_EN
      sgn_q   <= sgn_d;
      dv_q    <= dv_d;
      neg_q   <= neg_d;
      ra_q    <= ra_d;
`endif
    end
  end
endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// tb_hilo_muldiv_sequencer: directed and random checks of HI/LO sequencing against an arithmetic model.
module tb_hilo_muldiv_sequencer;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  hilo_muldiv_if #(.WIDTH(W)) bus ();
  hilo_muldiv_sequencer #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  function automatic logic [2*W-1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W-1:0] sa, sb;
    logic signed [2*W-1:0] sp;
    sa = a;
    sb = b;
    if (op == 3'd1) return {{W{1'b0}}, a} * {{W{1'b0}}, b};
    if (b == '0) return {a, {W{1'b1}}};
    if (op == 3'd2) return {a % b, a / b};
    if (op == 3'd5) begin
      sp = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
      return sp;
    end
    return {sa % sb, sa / sb};
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output int cyc);
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
    @(negedge clk);
    bus.op_valid = 1'b0; bus.op = 3'd0;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 100) begin cyc++; @(negedge clk); end
  endtask

  task automatic test_reset;
    #1;
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_chk++; if (bus.hi !== '0) begin n_fail++; $display("FAIL reset_hi got %h want 0", bus.hi); end
    n_chk++; if (bus.lo !== '0) begin n_fail++; $display("FAIL reset_lo got %h want 0", bus.lo); end
    n_chk++; if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz got %b want 0", bus.div_by_zero); end
    bus.op_valid = 1'b1; bus.op = 3'd3;
    #1;
    n_chk++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", bus.stall); end
    n_chk++; if (bus.result_valid !== 1'b1 || bus.result !== '0) begin n_fail++; $display("FAIL reset_mfhi got v=%b r=%h want v=1 r=0", bus.result_valid, bus.result); end
    bus.op_valid = 1'b0; bus.op = 3'd0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_multu_max;
    int c;
    logic [2*W-1:0] e;
    e = model(3'd1, '1, '1);
    run_op(3'd1, '1, '1, c);
    n_chk++; if (c !== W) begin n_fail++; $display("FAIL multu_busy_cycles got %0d want %0d", c, W); end
    n_chk++; if (bus.hi !== e[2*W-1:W]) begin n_fail++; $display("FAIL multu_hi got %h want %h", bus.hi, e[2*W-1:W]); end
    n_chk++; if (bus.lo !== e[W-1:0]) begin n_fail++; $display("FAIL multu_lo got %h want %h", bus.lo, e[W-1:0]); end
  endtask

  task automatic test_mflo_stall;
    int n;
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op = 3'd2; bus.src_a = 100; bus.src_b = 7;
    @(negedge clk);
    bus.op_valid = 1'b0;
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op = 3'd4;
    #1;
    n = 0;
    while (bus.stall === 1'b1 && n < 100) begin n++; @(negedge clk); #1; end
    n_chk++; if (n !== W - 1) begin n_fail++; $display("FAIL mflo_stall_cycles got %0d want %0d", n, W - 1); end
    n_chk++; if (bus.result_valid !== 1'b1 || bus.result !== 32'd14) begin n_fail++; $display("FAIL mflo_result got v=%b r=%0d want v=1 r=14", bus.result_valid, bus.result); end
    n_chk++; if (bus.hi !== 32'd2) begin n_fail++; $display("FAIL divu_hi got %0d want 2", bus.hi); end
    bus.op_valid = 1'b0; bus.op = 3'd0;
  endtask

  task automatic test_div_zero;
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op = 3'd2; bus.src_a = 32'h1234; bus.src_b = '0;
    @(negedge clk);
    bus.op_valid = 1'b0; bus.op = 3'd0;
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL div0_busy got %b want 0", bus.busy); end
    n_chk++; if (bus.hi !== 32'h1234 || bus.lo !== '1) begin n_fail++; $display("FAIL div0_hilo got %h/%h want 00001234/ffffffff", bus.hi, bus.lo); end
    n_chk++; if (bus.div_by_zero !== 1'b1) begin n_fail++; $display("FAIL div0_flag got %b want 1", bus.div_by_zero); end
    @(negedge clk);
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL div0_busy_later got %b want 0", bus.busy); end
  endtask

  task automatic start_mul_to_cycle10;
    int c;
    run_op(3'd2, 47, 7, c);
    n_chk++; if (bus.hi !== 32'd5 || bus.lo !== 32'd6) begin n_fail++; $display("FAIL prior_hilo got %0d/%0d want 5/6", bus.hi, bus.lo); end
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op = 3'd1; bus.src_a = 3; bus.src_b = 4;
    @(negedge clk);
    bus.op_valid = 1'b0; bus.op = 3'd0;
    repeat (9) @(negedge clk);
    n_chk++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL cycle10_busy got %b want 1", bus.busy); end
  endtask

  task automatic test_flush;
    start_mul_to_cycle10();
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got %b want 0", bus.busy); end
    n_chk++; if (bus.hi !== 32'd5 || bus.lo !== 32'd6) begin n_fail++; $display("FAIL flush_hilo got %0d/%0d want 5/6", bus.hi, bus.lo); end
    repeat (40) @(negedge clk);
    n_chk++; if (bus.hi !== 32'd5 || bus.lo !== 32'd6) begin n_fail++; $display("FAIL flush_hilo_later got %0d/%0d want 5/6", bus.hi, bus.lo); end
  endtask

  task automatic test_reset_mid;
    start_mul_to_cycle10();
    rst_n = 1'b0;
    #1;
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy got %b want 0", bus.busy); end
    n_chk++; if (bus.hi !== '0 || bus.lo !== '0) begin n_fail++; $display("FAIL arst_hilo got %h/%h want 0/0", bus.hi, bus.lo); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back;
    int n, c;
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op = 3'd1; bus.src_a = 2; bus.src_b = 3;
    @(negedge clk);
    bus.op = 3'd2; bus.src_a = 9; bus.src_b = 2;
    #1;
    n = 0;
    while (bus.stall === 1'b1 && n < 100) begin n++; @(negedge clk); #1; end
    n_chk++; if (n !== W) begin n_fail++; $display("FAIL b2b_stall got %0d want %0d", n, W); end
    n_chk++; if (bus.hi !== 32'd0 || bus.lo !== 32'd6) begin n_fail++; $display("FAIL b2b_first got %0d/%0d want 0/6", bus.hi, bus.lo); end
    @(negedge clk);
    bus.op_valid = 1'b0; bus.op = 3'd0;
    c = 0;
    while (bus.busy === 1'b1 && c < 100) begin c++; @(negedge clk); end
    n_chk++; if (c !== W) begin n_fail++; $display("FAIL b2b_busy got %0d want %0d", c, W); end
    n_chk++; if (bus.hi !== 32'd1 || bus.lo !== 32'd4) begin n_fail++; $display("FAIL b2b_final got %0d/%0d want 1/4", bus.hi, bus.lo); end
  endtask

  task automatic test_random(input bit sgn);
    int c, ec;
    logic [2:0] op;
    logic [W-1:0] a, b;
    logic [2*W-1:0] e;
    for (int i = 0; i < 24; i++) begin
      op = sgn ? (($urandom % 2) ? 3'd5 : 3'd6) : (($urandom % 2) ? 3'd1 : 3'd2);
      a = $urandom;
      case ($urandom % 4)
        0: b = '0;
        1: b = $urandom % 16;
        default: b = $urandom;
      endcase
      if (op == 3'd6 && a == 32'h8000_0000 && b == '1) b = 1;
      e = model(op, a, b);
      ec = ((op == 3'd2 || op == 3'd6) && b == '0) ? 0 : (sgn ? W + 1 : W);
      run_op(op, a, b, c);
      n_chk++; if (c !== ec) begin n_fail++; $display("FAIL rand_cycles op=%0d a=%h b=%h got %0d want %0d", op, a, b, c, ec); end
      n_chk++; if (bus.hi !== e[2*W-1:W] || bus.lo !== e[W-1:0]) begin n_fail++; $display("FAIL rand_hilo op=%0d a=%h b=%h got %h/%h want %h/%h", op, a, b, bus.hi, bus.lo, e[2*W-1:W], e[W-1:0]); end
      n_chk++; if (bus.div_by_zero !== (ec == 0)) begin n_fail++; $display("FAIL rand_dbz op=%0d b=%h got %b want %b", op, b, bus.div_by_zero, ec == 0); end
      @(negedge clk);
      bus.op_valid = 1'b1; bus.op = 3'd3;
      #1;
      n_chk++; if (bus.result_valid !== 1'b1 || bus.result !== e[2*W-1:W]) begin n_fail++; $display("FAIL rand_mfhi got v=%b r=%h want v=1 r=%h", bus.result_valid, bus.result, e[2*W-1:W]); end
      bus.op_valid = 1'b0; bus.op = 3'd0;
    end
  endtask

`ifdef HILO_SIGNED_EN
  task automatic test_signed;
    int c;
    run_op(3'd5, -32'sd3, 32'sd5, c);
    n_chk++; if (c !== W + 1) begin n_fail++; $display("FAIL mult_cycles got %0d want %0d", c, W + 1); end
    n_chk++; if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL mult_hilo got %h/%h want ffffffff/fffffff1", bus.hi, bus.lo); end
    run_op(3'd6, -32'sd7, 32'sd2, c);
    n_chk++; if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_hilo got %h/%h want ffffffff/fffffffd", bus.hi, bus.lo); end
    test_random(1'b1);
  endtask
`else
  task automatic test_signed;
    logic [W-1:0] h, l;
    h = bus.hi;
    l = bus.lo;
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op = 3'd5; bus.src_a = 7; bus.src_b = 9;
    #1;
    n_chk++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL op5_stall got %b want 0", bus.stall); end
    @(negedge clk);
    bus.op_valid = 1'b0; bus.op = 3'd0;
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL op5_busy got %b want 0", bus.busy); end
    n_chk++; if (bus.hi !== h || bus.lo !== l) begin n_fail++; $display("FAIL op5_hilo got %h/%h want %h/%h", bus.hi, bus.lo, h, l); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.op_valid = 1'b0; bus.op = 3'd0; bus.src_a = '0; bus.src_b = '0; bus.flush = 1'b0;
    test_reset();
    test_multu_max();
    test_mflo_stall();
    test_div_zero();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random(1'b0);
    test_signed();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
